// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, EXE command encodings,
// instruction field positions and the control half of the ID/EX bundle.
package id_pkg;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 26;
  localparam int DEST_LSB = 21;
  localparam int SRC1_LSB = 16;
  localparam int SRC2_LSB = 11;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd5;
  localparam logic [5:0] OP_OR   = 6'd6;
  localparam logic [5:0] OP_XOR  = 6'd8;
  localparam logic [5:0] OP_ADDI = 6'd32;
  localparam logic [5:0] OP_SUBI = 6'd33;
  localparam logic [5:0] OP_LD   = 6'd36;
  localparam logic [5:0] OP_ST   = 6'd37;

  typedef enum logic [3:0] {
    EXE_NOP = 4'd0,
    EXE_ADD = 4'd1,
    EXE_SUB = 4'd3,
    EXE_AND = 4'd5,
    EXE_OR  = 4'd6,
    EXE_XOR = 4'd8
  } exe_cmd_e;

  typedef struct packed {
    logic     valid;
    exe_cmd_e exe_cmd;
    logic     is_imm;
    logic     mem_r_en;
    logic     mem_w_en;
    logic     wb_en;
  } id_ex_ctrl_t;

  // A bubble must never write memory or the register file.
  function automatic id_ex_ctrl_t bubble(input id_ex_ctrl_t c);
    id_ex_ctrl_t b;
    b          = c;
    b.valid    = 1'b0;
    b.mem_r_en = 1'b0;
    b.mem_w_en = 1'b0;
    b.wb_en    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/id_ctrl_dec.sv
// Pure opcode decode into ALU command and pipeline control bits.
module id_ctrl_dec
  import id_pkg::*;
(
  input  logic [5:0] opcode_i,
  output exe_cmd_e   exe_cmd_o,
  output logic       is_imm_o,
  output logic       mem_r_en_o,
  output logic       mem_w_en_o,
  output logic       wb_en_o
);

  // Opcode to control lookup; unknown opcodes decode as a harmless NOP.
  always_comb begin
    exe_cmd_o  = EXE_NOP;
    is_imm_o   = 1'b0;
    mem_r_en_o = 1'b0;
    mem_w_en_o = 1'b0;
    wb_en_o    = 1'b0;
    case (opcode_i)
      OP_ADD:  begin exe_cmd_o = EXE_ADD; wb_en_o = 1'b1; end
      OP_SUB:  begin exe_cmd_o = EXE_SUB; wb_en_o = 1'b1; end
      OP_AND:  begin exe_cmd_o = EXE_AND; wb_en_o = 1'b1; end
      OP_OR:   begin exe_cmd_o = EXE_OR;  wb_en_o = 1'b1; end
      OP_XOR:  begin exe_cmd_o = EXE_XOR; wb_en_o = 1'b1; end
      OP_ADDI: begin exe_cmd_o = EXE_ADD; is_imm_o = 1'b1; wb_en_o = 1'b1; end
      OP_SUBI: begin exe_cmd_o = EXE_SUB; is_imm_o = 1'b1; wb_en_o = 1'b1; end
      OP_LD:   begin exe_cmd_o = EXE_ADD; is_imm_o = 1'b1; mem_r_en_o = 1'b1; wb_en_o = 1'b1; end
      OP_ST:   begin exe_cmd_o = EXE_ADD; is_imm_o = 1'b1; mem_w_en_o = 1'b1; end
      default: begin exe_cmd_o = EXE_NOP; end
    endcase
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered instruction-decode stage with load-use hazard detection and
// EX backpressure hold. Define ID_FWD_EN to add MEM-stage operand forwarding.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] reg1,
  input  logic [DATA_W-1:0] reg2,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_mem_r_en,
  input  logic              ex_ready,
  input  logic              flush,
`ifdef ID_FWD_EN
  input  logic [REG_AW-1:0] fwd_dest,
  input  logic [DATA_W-1:0] fwd_val,
  input  logic              fwd_wb_en,
`endif
  output logic              stall,
  output logic              out_valid,
  output logic [REG_AW-1:0] out_src1,
  output logic [REG_AW-1:0] out_src2,
  output logic [REG_AW-1:0] out_dest,
  output logic [DATA_W-1:0] out_reg2,
  output logic [DATA_W-1:0] out_val1,
  output logic [DATA_W-1:0] out_val2,
  output logic [3:0]        out_exe_cmd,
  output logic              out_mem_r_en,
  output logic              out_mem_w_en,
  output logic              out_wb_en,
  output logic              out_is_imm
);

  logic [REG_AW-1:0] dest_s, src1_s, src2_s;
  logic [DATA_W-1:0] src1_val_s, src2_val_s, imm_ext_s, val2_s;
  logic              hazard_s, hold_s;
  id_ex_ctrl_t       dec_s;

  id_ex_ctrl_t       ctrl_d, ctrl_q;
  logic [REG_AW-1:0] src1_d, src1_q, src2_d, src2_q, dest_d, dest_q;
  logic [DATA_W-1:0] reg2_d, reg2_q, val1_d, val1_q, val2_d, val2_q;

  assign dest_s = instruction[DEST_LSB +: REG_AW];
  assign src1_s = instruction[SRC1_LSB +: REG_AW];
  assign src2_s = instruction[SRC2_LSB +: REG_AW];

  id_ctrl_dec u_dec (
    .opcode_i   (instruction[OPC_MSB:OPC_LSB]),
    .exe_cmd_o  (dec_s.exe_cmd),
    .is_imm_o   (dec_s.is_imm),
    .mem_r_en_o (dec_s.mem_r_en),
    .mem_w_en_o (dec_s.mem_w_en),
    .wb_en_o    (dec_s.wb_en)
  );
  assign dec_s.valid = instr_valid;

`ifdef ID_FWD_EN
  assign src1_val_s = (fwd_wb_en && (fwd_dest != '0) && (fwd_dest == src1_s)) ? fwd_val : reg1;
  assign src2_val_s = (fwd_wb_en && (fwd_dest != '0) && (fwd_dest == src2_s)) ? fwd_val : reg2;
`else
  assign src1_val_s = reg1;
  assign src2_val_s = reg2;
`endif

  assign imm_ext_s = DATA_W'($signed(instruction[IMM_W-1:0]));
  assign val2_s    = dec_s.is_imm ? imm_ext_s : src2_val_s;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign hazard_s = instr_valid && ex_mem_r_en && (ex_dest != '0) &&
                    ((ex_dest == src1_s) || (!dec_s.is_imm && (ex_dest == src2_s)));
  assign hold_s   = ctrl_q.valid && !ex_ready;
  assign stall    = rst && !flush && (hazard_s || hold_s);

  // Next-state selection: flush beats hold beats hazard beats a normal load.
  always_comb begin
    ctrl_d = ctrl_q;
    src1_d = src1_q;
    src2_d = src2_q;
    dest_d = dest_q;
    reg2_d = reg2_q;
    val1_d = val1_q;
    val2_d = val2_q;
    if (flush) begin
      ctrl_d = bubble(ctrl_q);
    end else if (hold_s) begin
      ctrl_d = ctrl_q;
    end else if (hazard_s) begin
      ctrl_d = bubble(ctrl_q);
    end else begin
      ctrl_d = instr_valid ? dec_s : bubble(dec_s);
      src1_d = src1_s;
      src2_d = src2_s;
      dest_d = dest_s;
      reg2_d = src2_val_s;
      val1_d = src1_val_s;
      val2_d = val2_s;
    end
  end

  // ID/EX register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q <= '0;
      src1_q <= '0;
      src2_q <= '0;
      dest_q <= '0;
      reg2_q <= '0;
      val1_q <= '0;
      val2_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      src1_q <= src1_d;
      src2_q <= src2_d;
      dest_q <= dest_d;
      reg2_q <= reg2_d;
      val1_q <= val1_d;
      val2_q <= val2_d;
    end
  end

  assign out_valid    = ctrl_q.valid;
  assign out_exe_cmd  = ctrl_q.exe_cmd;
  assign out_is_imm   = ctrl_q.is_imm;
  assign out_mem_r_en = ctrl_q.mem_r_en;
  assign out_mem_w_en = ctrl_q.mem_w_en;
  assign out_wb_en    = ctrl_q.wb_en;
  assign out_src1     = src1_q;
  assign out_src2     = src2_q;
  assign out_dest     = dest_q;
  assign out_reg2     = reg2_q;
  assign out_val1     = val1_q;
  assign out_val2     = val2_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe; forwarding checks run when ID_FWD_EN is defined.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] reg1, reg2;
  logic [4:0]  ex_dest;
  logic        ex_mem_r_en, ex_ready, flush;
`ifdef ID_FWD_EN
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_val;
  logic        fwd_wb_en;
`endif
  logic        stall, out_valid;
  logic [4:0]  out_src1, out_src2, out_dest;
  logic [31:0] out_reg2, out_val1, out_val2;
  logic [3:0]  out_exe_cmd;
  logic        out_mem_r_en, out_mem_w_en, out_wb_en, out_is_imm;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  id_stage_pipe #(.DATA_W(32), .IMM_W(16), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction(instruction),
    .reg1(reg1), .reg2(reg2), .ex_dest(ex_dest), .ex_mem_r_en(ex_mem_r_en),
    .ex_ready(ex_ready), .flush(flush),
`ifdef ID_FWD_EN
    .fwd_dest(fwd_dest), .fwd_val(fwd_val), .fwd_wb_en(fwd_wb_en),
`endif
    .stall(stall), .out_valid(out_valid), .out_src1(out_src1), .out_src2(out_src2),
    .out_dest(out_dest), .out_reg2(out_reg2), .out_val1(out_val1), .out_val2(out_val2),
    .out_exe_cmd(out_exe_cmd), .out_mem_r_en(out_mem_r_en), .out_mem_w_en(out_mem_w_en),
    .out_wb_en(out_wb_en), .out_is_imm(out_is_imm)
  );

  function automatic logic [31:0] mk_r(input logic [5:0] op, input logic [4:0] d,
                                       input logic [4:0] s1, input logic [4:0] s2);
    return {op, d, s1, s2, 11'd0};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] d,
                                       input logic [4:0] s1, input logic [15:0] imm);
    return {op, d, s1, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    instr_valid = 1'b1; ex_mem_r_en = 1'b1; ex_dest = 5'd5;
    instruction = mk_i(6'd36, 5'd7, 5'd5, 16'h0004);
    reg1 = 32'd1; reg2 = 32'd2;
`ifdef ID_FWD_EN
    fwd_dest = 5'd0; fwd_val = 32'd0; fwd_wb_en = 1'b0;
`endif
    step(); step();
    nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL reset_stall got %b exp 0", stall); end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    nvec++; if ({out_val1, out_val2, out_reg2} !== 96'd0) begin nerr++; $display("FAIL reset_data got %h exp 0", {out_val1, out_val2, out_reg2}); end
    nvec++; if ({out_exe_cmd, out_mem_r_en, out_mem_w_en, out_wb_en, out_is_imm, out_dest, out_src1, out_src2} !== 23'd0) begin
      nerr++; $display("FAIL reset_ctrl got %h exp 0", {out_exe_cmd, out_mem_r_en, out_mem_w_en, out_wb_en, out_is_imm, out_dest, out_src1, out_src2});
    end
    rst = 1'b1; ex_mem_r_en = 1'b0; ex_dest = 5'd0;
  endtask

  task automatic test_addi();
    instruction = mk_i(6'd32, 5'd3, 5'd1, 16'hFFFC); reg1 = 32'd10; reg2 = 32'd55;
    step();
    nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL addi_valid got %b exp 1", out_valid); end
    nvec++; if (out_val1 !== 32'd10) begin nerr++; $display("FAIL addi_val1 got %h exp 0000000a", out_val1); end
    nvec++; if (out_val2 !== 32'hFFFFFFFC) begin nerr++; $display("FAIL addi_val2 got %h exp fffffffc", out_val2); end
    nvec++; if ({out_is_imm, out_wb_en, out_mem_r_en, out_mem_w_en} !== 4'b1100) begin nerr++; $display("FAIL addi_ctrl got %b exp 1100", {out_is_imm, out_wb_en, out_mem_r_en, out_mem_w_en}); end
    nvec++; if ({out_exe_cmd, out_dest, out_src1} !== {4'd1, 5'd3, 5'd1}) begin nerr++; $display("FAIL addi_fields got %h exp %h", {out_exe_cmd, out_dest, out_src1}, {4'd1, 5'd3, 5'd1}); end
  endtask

  task automatic test_rtype();
    instruction = mk_r(6'd3, 5'd4, 5'd1, 5'd2); reg1 = 32'd20; reg2 = 32'd7;
    step();
    nvec++; if ({out_val1, out_val2, out_reg2} !== {32'd20, 32'd7, 32'd7}) begin nerr++; $display("FAIL sub_data got %h exp %h", {out_val1, out_val2, out_reg2}, {32'd20, 32'd7, 32'd7}); end
    nvec++; if ({out_exe_cmd, out_is_imm, out_wb_en, out_src2} !== {4'd3, 1'b0, 1'b1, 5'd2}) begin nerr++; $display("FAIL sub_ctrl got %h exp %h", {out_exe_cmd, out_is_imm, out_wb_en, out_src2}, {4'd3, 1'b0, 1'b1, 5'd2}); end
  endtask

  task automatic test_load_use();
    instruction = mk_r(6'd1, 5'd6, 5'd1, 5'd5); reg1 = 32'd1; reg2 = 32'd2;
    ex_mem_r_en = 1'b1; ex_dest = 5'd5;
    #1;
    nvec++; if (stall !== 1'b1) begin nerr++; $display("FAIL lu_stall got %b exp 1", stall); end
    step();
    nvec++; if ({out_valid, out_wb_en} !== 2'b00) begin nerr++; $display("FAIL lu_bubble got %b exp 00", {out_valid, out_wb_en}); end
    ex_mem_r_en = 1'b0; ex_dest = 5'd0;
    #1;
    nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL lu_release got %b exp 0", stall); end
    step();
    nvec++; if ({out_valid, out_wb_en, out_src2, out_dest} !== {1'b1, 1'b1, 5'd5, 5'd6}) begin nerr++; $display("FAIL lu_issue got %h exp %h", {out_valid, out_wb_en, out_src2, out_dest}, {1'b1, 1'b1, 5'd5, 5'd6}); end
  endtask

  task automatic test_imm_hazard();
    ex_mem_r_en = 1'b1; ex_dest = 5'd5;
    instruction = mk_i(6'd32, 5'd6, 5'd1, 16'h2800);
    #1;
    nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL imm_src2_stall got %b exp 0", stall); end
    step();
    nvec++; if ({out_valid, out_val2} !== {1'b1, 32'h00002800}) begin nerr++; $display("FAIL imm_src2_issue got %h exp %h", {out_valid, out_val2}, {1'b1, 32'h00002800}); end
    instruction = mk_i(6'd36, 5'd7, 5'd5, 16'h0004);
    #1;
    nvec++; if (stall !== 1'b1) begin nerr++; $display("FAIL imm_src1_stall got %b exp 1", stall); end
    step();
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL imm_src1_bubble got %b exp 0", out_valid); end
    ex_dest = 5'd0; instruction = mk_r(6'd1, 5'd1, 5'd0, 5'd0);
    #1;
    nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL r0_stall got %b exp 0", stall); end
    step();
    nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL r0_issue got %b exp 1", out_valid); end
    ex_mem_r_en = 1'b0;
  endtask

  task automatic test_hold_flush();
    instruction = mk_r(6'd3, 5'd4, 5'd1, 5'd2); reg1 = 32'd20; reg2 = 32'd7;
    step();
    ex_ready = 1'b0; instruction = mk_i(6'd32, 5'd9, 5'd1, 16'h0001); reg1 = 32'd1;
    #1;
    nvec++; if (stall !== 1'b1) begin nerr++; $display("FAIL hold_stall got %b exp 1", stall); end
    step();
    nvec++; if ({out_valid, out_dest, out_val1, out_exe_cmd} !== {1'b1, 5'd4, 32'd20, 4'd3}) begin nerr++; $display("FAIL hold_frozen got %h exp %h", {out_valid, out_dest, out_val1, out_exe_cmd}, {1'b1, 5'd4, 32'd20, 4'd3}); end
    flush = 1'b1;
    #1;
    nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL flush_stall got %b exp 0", stall); end
    step();
    nvec++; if ({out_valid, out_wb_en, out_mem_r_en, out_mem_w_en} !== 4'b0000) begin nerr++; $display("FAIL flush_kill got %b exp 0000", {out_valid, out_wb_en, out_mem_r_en, out_mem_w_en}); end
    flush = 1'b0;
    #1;
    nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL after_flush_stall got %b exp 0", stall); end
    step();
    nvec++; if ({out_valid, out_dest} !== {1'b1, 5'd9}) begin nerr++; $display("FAIL after_flush_load got %h exp %h", {out_valid, out_dest}, {1'b1, 5'd9}); end
    ex_ready = 1'b1;
  endtask

  task automatic test_hold_hazard();
    ex_ready = 1'b0; ex_mem_r_en = 1'b1; ex_dest = 5'd1;
    instruction = mk_r(6'd1, 5'd2, 5'd1, 5'd3);
    #1;
    nvec++; if (stall !== 1'b1) begin nerr++; $display("FAIL hh_stall got %b exp 1", stall); end
    step();
    nvec++; if ({out_valid, out_dest} !== {1'b1, 5'd9}) begin nerr++; $display("FAIL hh_hold got %h exp %h", {out_valid, out_dest}, {1'b1, 5'd9}); end
    ex_ready = 1'b1;
    #1;
    nvec++; if (stall !== 1'b1) begin nerr++; $display("FAIL hh_hazard_stall got %b exp 1", stall); end
    step();
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL hh_bubble got %b exp 0", out_valid); end
    ex_mem_r_en = 1'b0;
    step();
    nvec++; if ({out_valid, out_dest} !== {1'b1, 5'd2}) begin nerr++; $display("FAIL hh_issue got %h exp %h", {out_valid, out_dest}, {1'b1, 5'd2}); end
  endtask

  task automatic test_store_invalid();
    instruction = mk_i(6'd37, 5'd0, 5'd2, 16'h0010); reg1 = 32'd100; reg2 = 32'd55;
    step();
    nvec++; if ({out_mem_w_en, out_mem_r_en, out_wb_en} !== 3'b100) begin nerr++; $display("FAIL st_ctrl got %b exp 100", {out_mem_w_en, out_mem_r_en, out_wb_en}); end
    nvec++; if ({out_val1, out_val2, out_reg2} !== {32'd100, 32'd16, 32'd55}) begin nerr++; $display("FAIL st_data got %h exp %h", {out_val1, out_val2, out_reg2}, {32'd100, 32'd16, 32'd55}); end
    instr_valid = 1'b0; instruction = mk_r(6'd1, 5'd8, 5'd1, 5'd2);
    step();
    nvec++; if ({out_valid, out_wb_en} !== 2'b00) begin nerr++; $display("FAIL invalid_bubble got %b exp 00", {out_valid, out_wb_en}); end
    instr_valid = 1'b1;
  endtask

`ifdef ID_FWD_EN
  task automatic test_forward();
    instruction = mk_r(6'd1, 5'd3, 5'd2, 5'd4); reg1 = 32'd7; reg2 = 32'd8;
    fwd_dest = 5'd2; fwd_val = 32'd99; fwd_wb_en = 1'b1;
    step();
    nvec++; if ({out_val1, out_val2} !== {32'd99, 32'd8}) begin nerr++; $display("FAIL fwd_src1 got %h exp %h", {out_val1, out_val2}, {32'd99, 32'd8}); end
    fwd_dest = 5'd4;
    step();
    nvec++; if ({out_val1, out_val2, out_reg2} !== {32'd7, 32'd99, 32'd99}) begin nerr++; $display("FAIL fwd_src2 got %h exp %h", {out_val1, out_val2, out_reg2}, {32'd7, 32'd99, 32'd99}); end
    fwd_dest = 5'd0; instruction = mk_r(6'd1, 5'd3, 5'd0, 5'd4); reg1 = 32'd7;
    step();
    nvec++; if (out_val1 !== 32'd7) begin nerr++; $display("FAIL fwd_r0 got %h exp 00000007", out_val1); end
    fwd_wb_en = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_hold();
    instruction = mk_r(6'd1, 5'd6, 5'd1, 5'd2); reg1 = 32'd33;
    step();
    ex_ready = 1'b0;
    step();
    nvec++; if ({out_valid, out_val1} !== {1'b1, 32'd33}) begin nerr++; $display("FAIL pre_reset_hold got %h exp %h", {out_valid, out_val1}, {1'b1, 32'd33}); end
    #2; rst = 1'b0; #1;
    nvec++; if ({out_valid, out_wb_en, out_val1, out_dest} !== 39'd0) begin nerr++; $display("FAIL async_reset got %h exp 0", {out_valid, out_wb_en, out_val1, out_dest}); end
    nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL async_reset_stall got %b exp 0", stall); end
    #1; rst = 1'b1; ex_ready = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_rtype();
    test_load_use();
    test_imm_hazard();
    test_hold_flush();
    test_hold_hazard();
    test_store_invalid();
`ifdef ID_FWD_EN
    test_forward();
`endif
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
